mem_arbiter: RTL and testbench

Single-port memory arbiter and sequencer that lets the RV32I pipeline's instruction-fetch and data-access streams share one unified memory port. It accepts one request at a time from each of two requesters (fetch, data) and picks a winner with data-over-fetch priority plus a fetch starvation guard. It issues the winning transaction to the memory with a ready/valid handshake and returns the response to the owning requester. It sits between the core's imem/dmem ports and the external memory model.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets instruction fetch and data access share one memory port.
// Data wins contention unless fetch has lost MAX_WAIT arbitrations in a row,
// at most one transaction is outstanding, and a latched transaction always
// runs to completion even if its requester withdraws.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iGnt,
    output logic              iValid,
    output logic [DATA_W-1:0] iRdata,
    input  logic              dReq,
    input  logic              dWen,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic              memReq,
    output logic              memWen,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic              memReady,
    input  logic              memRvalid,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    state_t            state_q,     state_d;
    owner_t            owner_q,     owner_d;
    logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
    logic              memReq_q,    memReq_d;
    logic              memWen_q,    memWen_d;
    logic [ADDR_W-1:0] memAddr_q,   memAddr_d;
    logic [DATA_W-1:0] memWdata_q,  memWdata_d;
    logic [DATA_W-1:0] iRdata_q,    iRdata_d;
    logic [DATA_W-1:0] dRdata_q,    dRdata_d;
    logic              iValid_q,    iValid_d;
    logic              dValid_q,    dValid_d;
    logic              fetchWins;

    // State register and all latched transaction/response fields.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            starveCnt_q <= '0;
            memReq_q    <= 1'b0;
            memWen_q    <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            iValid_q    <= 1'b0;
            dValid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starveCnt_q <= starveCnt_d;
            memReq_q    <= memReq_d;
            memWen_q    <= memWen_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
            iValid_q    <= iValid_d;
            dValid_q    <= dValid_d;
        end
    end

    // Arbitration, issue handshake and response routing; grants are combinational from memReady.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starveCnt_d = starveCnt_q;
        memWen_d    = memWen_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        iValid_d    = 1'b0;
        dValid_d    = 1'b0;
        iGnt        = 1'b0;
        dGnt        = 1'b0;
        fetchWins   = 1'b0;

        case (state_q)
            IDLE: begin
                if (iReq || dReq) begin
                    fetchWins = iReq && (!dReq || (starveCnt_q == CNT_MAX));
                    if (fetchWins) begin
                        owner_d     = OWN_FETCH;
                        memWen_d    = 1'b0;
                        memAddr_d   = iAddr;
                        memWdata_d  = '0;
                        starveCnt_d = '0;
                    end else begin
                        owner_d    = OWN_DATA;
                        memWen_d   = dWen;
                        memAddr_d  = dAddr;
                        memWdata_d = dWdata;
                        if (iReq && (starveCnt_q != CNT_MAX)) begin
                            starveCnt_d = starveCnt_q + CNT_W'(1);
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (memReady) begin
                    iGnt    = (owner_q == OWN_FETCH);
                    dGnt    = (owner_q == OWN_DATA);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (memRvalid) begin
                    if (owner_q == OWN_FETCH) begin
                        iRdata_d = memRdata;
                        iValid_d = 1'b1;
                    end else begin
                        dRdata_d = memRdata;
                        dValid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        memReq_d = (state_d == ISSUE);
    end

    assign memReq   = memReq_q;
    assign memWen   = memWen_q;
    assign memAddr  = memAddr_q;
    assign memWdata = memWdata_q;
    assign iRdata   = iRdata_q;
    assign dRdata   = dRdata_q;
    assign iValid   = iValid_q;
    assign dValid   = dValid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard; expected grants and
// responses are queued at stimulus time and popped by an independent monitor.
module tb_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rstN;
    logic              iReq;
    logic [ADDR_W-1:0] iAddr;
    logic              iGnt;
    logic              iValid;
    logic [DATA_W-1:0] iRdata;
    logic              dReq;
    logic              dWen;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dGnt;
    logic              dValid;
    logic [DATA_W-1:0] dRdata;
    logic              memReq;
    logic              memWen;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memReady;
    logic              memRvalid;
    logic [DATA_W-1:0] memRdata;

    typedef struct {
        bit          isData;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          issueCycles;
    } gntExp_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } rspExp_t;

    typedef enum {P_IDLE, P_REQ, P_RESP} rphase_t;

    gntExp_t     gntQ[$];
    rspExp_t     iQ[$];
    rspExp_t     dQ[$];
    logic [31:0] respQ[$];

    int numCompared   = 0;
    int numMismatched = 0;
    int readyStall    = 0;
    int rvalidWait    = 0;
    int reqCycles     = 0;
    bit strayReq      = 1'b0;
    bit realRvalid    = 1'b0;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .iGnt     (iGnt),
        .iValid   (iValid),
        .iRdata   (iRdata),
        .dReq     (dReq),
        .dWen     (dWen),
        .dAddr    (dAddr),
        .dWdata   (dWdata),
        .dGnt     (dGnt),
        .dValid   (dValid),
        .dRdata   (dRdata),
        .memReq   (memReq),
        .memWen   (memWen),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memReady (memReady),
        .memRvalid(memRvalid),
        .memRdata (memRdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        numCompared++;
        numMismatched++;
        $display("[TB] FAIL %s: got an unexpected pulse, expected none", name);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dropRequests();
        iReq = 1'b0;
        dReq = 1'b0;
    endtask

    // Queue one transaction's expected grant and response plus the data memory will return.
    task automatic expectTxn(input bit isData, input bit wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int issueCycles);
        gntQ.push_back('{isData, wen, addr, wdata, issueCycles});
        respQ.push_back(rdata);
        if (isData) dQ.push_back('{!wen, rdata});
        else        iQ.push_back('{1'b1, rdata});
    endtask

    // Single requester transaction, measuring grant and valid cycles relative to cycle 0.
    task automatic applyStimulus(input bit isData, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int stall, input int rwait, input bit dropEarly,
                                 input string name);
        int gntAt = -1;
        int validAt = -1;
        readyStall = stall;
        rvalidWait = rwait;
        expectTxn(isData, wen, addr, wdata, rdata, stall + 1);
        nextCycle();
        if (isData) begin
            dReq = 1'b1; dWen = wen; dAddr = addr; dWdata = wdata;
        end else begin
            iReq = 1'b1; iAddr = addr;
        end
        for (int n = 0; n < 40 && validAt < 0; n++) begin
            @(negedge clk);
            if ((iGnt || dGnt) && gntAt < 0) gntAt = n;
            if (iValid || dValid) validAt = n;
            nextCycle();
            if (dropEarly && n == 0) dropRequests();
            if (gntAt >= 0) dropRequests();
        end
        dropRequests();
        checkOutput({name, "GntCycle"}, 32'(gntAt), 32'(1 + stall));
        checkOutput({name, "ValidCycle"}, 32'(validAt), 32'(3 + stall + rwait));
    endtask

    task automatic waitDrained(input string name);
        int n = 0;
        while ((gntQ.size() != 0 || iQ.size() != 0 || dQ.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "Drained"}, 32'(n < 100), 32'd1);
    endtask

    // Memory model: stalls memReady and delays memRvalid by the configured cycle counts.
    initial begin : responder
        rphase_t phase = P_IDLE;
        int  left = 0;
        bit  prevReady;
        bit  prevRvalid;
        bit  strayDone = 1'b0;
        memReady  = 1'b0;
        memRvalid = 1'b0;
        memRdata  = '0;
        forever begin
            nextCycle();
            prevReady  = memReady;
            prevRvalid = realRvalid;
            memReady   = 1'b0;
            memRvalid  = 1'b0;
            realRvalid = 1'b0;
            if (!rstN) begin
                phase = P_IDLE;
                continue;
            end
            if (phase == P_REQ && prevReady) begin
                phase = P_RESP;
                left  = rvalidWait;
            end else if (phase == P_RESP && prevRvalid) begin
                phase = P_IDLE;
            end
            if (phase == P_IDLE && memReq) begin
                phase = P_REQ;
                left  = readyStall;
            end
            case (phase)
                P_REQ: begin
                    if (left == 0) memReady = 1'b1;
                    else left--;
                end
                P_RESP: begin
                    if (left == 0) begin
                        memRvalid  = 1'b1;
                        realRvalid = 1'b1;
                        memRdata   = (respQ.size() != 0) ? respQ.pop_front() : 32'hBAD0BAD0;
                    end else begin
                        left--;
                    end
                end
                default: begin
                    if (strayReq && !strayDone) begin
                        memRvalid = 1'b1;
                        memRdata  = 32'hFFFF0000;
                        strayDone = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops expected grants/responses whenever the DUT pulses Gnt or Valid.
    initial begin : monitor
        gntExp_t e;
        rspExp_t r;
        bit prevRealRvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                reqCycles      = 0;
                prevRealRvalid = 1'b0;
                continue;
            end
            if (memReq) reqCycles++;
            if (memReady || iGnt || dGnt)
                checkOutput("gntTiming", 32'(iGnt | dGnt), 32'(memReady));
            if (iGnt || dGnt) begin
                if (gntQ.size() == 0) begin
                    reportUnexpected("unexpectedGnt");
                end else begin
                    e = gntQ.pop_front();
                    checkOutput("gntOwnerD", 32'(dGnt), 32'(e.isData));
                    checkOutput("gntOwnerI", 32'(iGnt), 32'(!e.isData));
                    checkOutput("memWen", 32'(memWen), 32'(e.wen));
                    checkOutput("memAddr", memAddr, e.addr);
                    if (e.wen) checkOutput("memWdata", memWdata, e.wdata);
                    checkOutput("memReqCycles", 32'(reqCycles), 32'(e.issueCycles));
                end
                reqCycles = 0;
            end
            if (iValid || dValid || prevRealRvalid)
                checkOutput("validTiming", 32'(iValid | dValid), 32'(prevRealRvalid));
            if (iValid) begin
                if (iQ.size() == 0) reportUnexpected("unexpectedIValid");
                else begin
                    r = iQ.pop_front();
                    checkOutput("iRdata", iRdata, r.data);
                end
            end
            if (dValid) begin
                if (dQ.size() == 0) reportUnexpected("unexpectedDValid");
                else begin
                    r = dQ.pop_front();
                    if (r.chk) checkOutput("dRdata", dRdata, r.data);
                end
            end
            prevRealRvalid = realRvalid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin : stimulus
        int cnt;
        int n;
        rstN = 1'b1;
        iReq = 1'b0; iAddr = '0;
        dReq = 1'b0; dWen = 1'b0; dAddr = '0; dWdata = '0;
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstMemReq",   32'(memReq),   32'd0);
        checkOutput("rstMemWen",   32'(memWen),   32'd0);
        checkOutput("rstMemAddr",  memAddr,       32'd0);
        checkOutput("rstMemWdata", memWdata,      32'd0);
        checkOutput("rstIGnt",     32'(iGnt),     32'd0);
        checkOutput("rstDGnt",     32'(dGnt),     32'd0);
        checkOutput("rstIValid",   32'(iValid),   32'd0);
        checkOutput("rstDValid",   32'(dValid),   32'd0);
        checkOutput("rstIRdata",   iRdata,        32'd0);
        checkOutput("rstDRdata",   dRdata,        32'd0);
        nextCycle();
        rstN = 1'b1;

        $display("[TB] single load");
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, "load");
        waitDrained("load");

        $display("[TB] store with memReady backpressure");
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 3, 0, 1'b0, "store");
        waitDrained("store");

        $display("[TB] fetch only");
        applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h00500093, 0, 0, 1'b0, "fetch");
        waitDrained("fetch");

        $display("[TB] contention");
        readyStall = 0;
        rvalidWait = 1;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) expectTxn(1'b0, 1'b0, 32'h8,   32'h0, 32'h10000000 + 32'(k), 1);
            else              expectTxn(1'b1, 1'b0, 32'h400, 32'h0, 32'hD0000000 + 32'(k), 1);
        end
        nextCycle();
        iReq = 1'b1; iAddr = 32'h8;
        dReq = 1'b1; dWen = 1'b0; dAddr = 32'h400; dWdata = '0;
        cnt = 0;
        n = 0;
        while (cnt < 10 && n < 200) begin
            @(negedge clk);
            if (iGnt || dGnt) cnt++;
            n++;
        end
        nextCycle();
        dropRequests();
        checkOutput("contentionGnts", 32'(cnt), 32'd10);
        waitDrained("contention");

        $display("[TB] reset mid-transaction");
        readyStall = 0;
        rvalidWait = 6;
        gntQ.push_back('{1'b1, 1'b0, 32'h200, 32'h0, 1});
        respQ.push_back(32'h5555AAAA);
        nextCycle();
        dReq = 1'b1; dWen = 1'b0; dAddr = 32'h200;
        n = 0;
        while (!dGnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abortGntSeen", 32'(dGnt), 32'd1);
        nextCycle();
        dropRequests();
        nextCycle();
        #2 rstN = 1'b0;
        #1;
        checkOutput("abortMemReq",  32'(memReq), 32'd0);
        checkOutput("abortMemAddr", memAddr,     32'd0);
        checkOutput("abortIGnt",    32'(iGnt),   32'd0);
        checkOutput("abortDGnt",    32'(dGnt),   32'd0);
        checkOutput("abortIValid",  32'(iValid), 32'd0);
        checkOutput("abortDValid",  32'(dValid), 32'd0);
        checkOutput("abortIRdata",  iRdata,      32'd0);
        checkOutput("abortDRdata",  dRdata,      32'd0);
        respQ.delete();
        repeat (2) nextCycle();
        rstN = 1'b1;
        strayReq = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("strayNoValid", 32'(iValid | dValid), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, "afterReset");
        waitDrained("afterReset");

        $display("[TB] requester withdraw");
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 32'h00A00113, 1, 0, 1'b1, "withdraw");
        waitDrained("withdraw");
        repeat (6) begin
            @(negedge clk);
            checkOutput("withdrawNoReissue", 32'(memReq), 32'd0);
        end

        checkOutput("endGntQ",      32'(gntQ.size()), 32'd0);
        checkOutput("endIQ",        32'(iQ.size()),   32'd0);
        checkOutput("endDQ",        32'(dQ.size()),   32'd0);
        checkOutput("endRespQ",     32'(respQ.size()), 32'd0);
        checkOutput("endReqCycles", 32'(reqCycles),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
